// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg
//   Shared definitions for the single-clock stream FIFO family.
//   Holds the drop counter width, the pointer control encoding used by
//   the top level, and a clog2 helper that later FIFO variants reuse.
//   No ports; imported with "import stream_fifo_pkg::*;".

package stream_fifo_pkg;

    // Width of the saturating discarded-write counter.
    localparam int FIFO_DROP_CNT_W = 16;

    // What the pointer logic does on the coming edge when not in reset.
    // Reset is handled directly in the register block.
    typedef enum logic [0:0] {
        CTRL_RUN   = 1'b0,
        CTRL_FLUSH = 1'b1
    } ptr_ctrl_e;

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// stream_fifo_ram
//   Simple dual-port storage array for stream_fifo: one synchronous
//   write port and one asynchronous read port. Contents are never reset.
// Ports
//   clk_i      : clock, rising edge
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : read data, combinational from rd_addr_i

module stream_fifo_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Asynchronous read gives the first-word-fall-through head directly.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo
//   Single-clock valid/ready stream FIFO with first-word-fall-through
//   output, fill level, almost-full/almost-empty flags, synchronous
//   flush and an optional drop-on-full mode with a saturating drop count.
// Ports
//   clk_i          : clock, rising edge
//   reset_i        : synchronous reset, active-high
//   flush_i        : synchronous empty request, contents discarded
//   in_valid_i     : write data valid
//   in_ready_o     : FIFO accepts a write this cycle
//   in_value_i     : write data
//   out_valid_o    : out_value_o holds the head entry
//   out_ready_i    : consumer takes the head this cycle
//   out_value_o    : head data
//   level_o        : number of stored entries, 0..depth
//   almost_full_o  : level_o >= AFULL_THRESH
//   almost_empty_o : level_o <= AEMPTY_THRESH
//   drop_o         : a write was discarded on the previous edge
//   drop_count_o   : saturating count of discarded writes

module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH    = 5,
    parameter int VALUE_WIDTH   = 8,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 2,
    parameter bit DROP_ON_FULL  = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [VALUE_WIDTH-1:0]     in_value_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [VALUE_WIDTH-1:0]     out_value_o,
    output logic [FIFO_WIDTH:0]        level_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic                       drop_o,
    output logic [FIFO_DROP_CNT_W-1:0] drop_count_o
);

    localparam int DEPTH = 2 ** FIFO_WIDTH;

    localparam logic [FIFO_WIDTH:0] DEPTH_LVL  = (FIFO_WIDTH + 1)'(DEPTH);
    localparam logic [FIFO_WIDTH:0] AFULL_LVL  = (FIFO_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [FIFO_WIDTH:0] AEMPTY_LVL = (FIFO_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [FIFO_WIDTH:0] PTR_ONE    = (FIFO_WIDTH + 1)'(1);

    localparam logic [FIFO_DROP_CNT_W-1:0] DROP_CNT_MAX = {FIFO_DROP_CNT_W{1'b1}};
    localparam logic [FIFO_DROP_CNT_W-1:0] DROP_CNT_ONE = FIFO_DROP_CNT_W'(1);

    // Parameter legality is rejected at elaboration time.
    if (FIFO_WIDTH < 1 || FIFO_WIDTH > 12) begin : g_bad_width
        $error("stream_fifo: FIFO_WIDTH must be 1..12");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("stream_fifo: AFULL_THRESH must be 1..depth");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("stream_fifo: AEMPTY_THRESH must be 0..depth-1");
    end

    logic [FIFO_WIDTH:0]          wr_ptr_q, wr_ptr_d;
    logic [FIFO_WIDTH:0]          rd_ptr_q, rd_ptr_d;
    logic                         drop_q, drop_d;
    logic [FIFO_DROP_CNT_W-1:0]   drop_count_q, drop_count_d;

    logic [FIFO_WIDTH:0]          level;
    logic                         empty;
    logic                         full;
    logic                         push;
    logic                         pop;
    logic                         drop_event;
    logic                         ram_wr_en;
    ptr_ctrl_e                    ptr_ctrl;

    // Status comes only from the registered pointers, so there is no
    // combinational path from the input side to the output side.
    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == DEPTH_LVL);

    // In drop mode the producer is never stalled; a write arriving while
    // full is discarded instead. Fullness is judged before any pop of the
    // same cycle, so such a write is dropped even if a slot frees up.
    assign push       = in_valid_i & ~full;
    assign pop        = ~empty & out_ready_i;
    assign drop_event = DROP_ON_FULL & in_valid_i & full;

    assign ptr_ctrl  = flush_i ? CTRL_FLUSH : CTRL_RUN;
    assign ram_wr_en = push & ~flush_i & ~reset_i;

    // Next-state for pointers and drop tracking. A flush empties the FIFO,
    // ignores any same-cycle push or pop, clears the drop pulse but leaves
    // the drop count untouched.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        drop_d       = 1'b0;
        drop_count_d = drop_count_q;
        unique case (ptr_ctrl)
            CTRL_FLUSH: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end
            default: begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
                drop_d = drop_event;
                if (drop_event && (drop_count_q != DROP_CNT_MAX)) begin
                    drop_count_d = drop_count_q + DROP_CNT_ONE;
                end
            end
        endcase
    end

    // State registers; reset has priority over everything else.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            drop_q       <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_q       <= drop_d;
            drop_count_q <= drop_count_d;
        end
    end

    stream_fifo_ram #(
        .ADDR_WIDTH (FIFO_WIDTH),
        .DATA_WIDTH (VALUE_WIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (wr_ptr_q[FIFO_WIDTH-1:0]),
        .wr_data_i (in_value_i),
        .rd_addr_i (rd_ptr_q[FIFO_WIDTH-1:0]),
        .rd_data_o (out_value_o)
    );

    assign in_ready_o     = DROP_ON_FULL ? 1'b1 : ~full;
    assign out_valid_o    = ~empty;
    assign level_o        = level;
    assign almost_full_o  = (level >= AFULL_LVL);
    assign almost_empty_o = (level <= AEMPTY_LVL);
    assign drop_o         = drop_q;
    assign drop_count_o   = drop_count_q;

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo
//   Drives a backpressure instance and a drop-on-full instance of
//   stream_fifo (depth 4) in lockstep with the same stimulus, comparing
//   both every cycle against queue-based reference models, plus directed
//   scenarios for reset, fill/drain, wrap, full-with-pop, flush and drop.

module tb_stream_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic [7:0]  inValue;
    logic        outReady;

    logic        inReady0, outValid0, afull0, aempty0, drop0;
    logic [7:0]  outValue0;
    logic [2:0]  level0;
    logic [15:0] dropCount0;

    logic        inReady1, outValid1, afull1, aempty1, drop1;
    logic [7:0]  outValue1;
    logic [2:0]  level1;
    logic [15:0] dropCount1;

    int checkCount = 0;
    int passCount  = 0;

    // Reference models: contents as queues, plus drop tracking for the
    // drop-mode instance.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       mDrop1;
    int         mDropCount1;

    always #5 clk = ~clk;

    stream_fifo #(
        .FIFO_WIDTH(2), .VALUE_WIDTH(8), .AFULL_THRESH(3),
        .AEMPTY_THRESH(1), .DROP_ON_FULL(1'b0)
    ) dutBp (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(inReady0), .in_value_i(inValue),
        .out_valid_o(outValid0), .out_ready_i(outReady), .out_value_o(outValue0),
        .level_o(level0), .almost_full_o(afull0), .almost_empty_o(aempty0),
        .drop_o(drop0), .drop_count_o(dropCount0)
    );

    stream_fifo #(
        .FIFO_WIDTH(2), .VALUE_WIDTH(8), .AFULL_THRESH(3),
        .AEMPTY_THRESH(1), .DROP_ON_FULL(1'b1)
    ) dutDrop (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(inReady1), .in_value_i(inValue),
        .out_valid_o(outValid1), .out_ready_i(outReady), .out_value_o(outValue1),
        .level_o(level1), .almost_full_o(afull1), .almost_empty_o(aempty1),
        .drop_o(drop1), .drop_count_o(dropCount1)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compare both instances against their models before the next edge.
    task automatic compareAll();
        checkOutput("bp valid",   32'(outValid0),  32'(q0.size() > 0));
        checkOutput("bp ready",   32'(inReady0),   32'(q0.size() < 4));
        checkOutput("bp level",   32'(level0),     q0.size());
        checkOutput("bp afull",   32'(afull0),     32'(q0.size() >= 3));
        checkOutput("bp aempty",  32'(aempty0),    32'(q0.size() <= 1));
        checkOutput("bp drop",    32'(drop0),      32'd0);
        checkOutput("bp dropcnt", 32'(dropCount0), 32'd0);
        if (q0.size() > 0) checkOutput("bp value", 32'(outValue0), 32'(q0[0]));

        checkOutput("dr valid",   32'(outValid1),  32'(q1.size() > 0));
        checkOutput("dr ready",   32'(inReady1),   32'd1);
        checkOutput("dr level",   32'(level1),     q1.size());
        checkOutput("dr afull",   32'(afull1),     32'(q1.size() >= 3));
        checkOutput("dr aempty",  32'(aempty1),    32'(q1.size() <= 1));
        checkOutput("dr drop",    32'(drop1),      32'(mDrop1));
        checkOutput("dr dropcnt", 32'(dropCount1), mDropCount1);
        if (q1.size() > 0) checkOutput("dr value", 32'(outValue1), 32'(q1[0]));
    endtask

    // Advance the models by one clock edge using pre-edge state.
    task automatic modelStep(input logic rst, input logic fl, input logic iv,
                             input logic [7:0] val, input logic ordy);
        logic doPop0, doPush0, doPop1, doPush1, doDrop1;
        doPop0  = ordy && (q0.size() > 0);
        doPush0 = iv && (q0.size() < 4);
        doPop1  = ordy && (q1.size() > 0);
        doPush1 = iv && (q1.size() < 4);
        doDrop1 = iv && (q1.size() == 4);
        if (rst) begin
            q0.delete();
            q1.delete();
            mDrop1      = 1'b0;
            mDropCount1 = 0;
        end else if (fl) begin
            q0.delete();
            q1.delete();
            mDrop1 = 1'b0;
        end else begin
            if (doPop0)  void'(q0.pop_front());
            if (doPush0) q0.push_back(val);
            if (doPop1)  void'(q1.pop_front());
            if (doPush1) q1.push_back(val);
            mDrop1 = doDrop1;
            if (doDrop1 && mDropCount1 < 65535) mDropCount1++;
        end
    endtask

    // One cycle: drive inputs, check, update model, cross the edge.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [7:0] val, input logic ordy);
        reset    = rst;
        flush    = fl;
        inValid  = iv;
        inValue  = val;
        outReady = ordy;
        #1;
        compareAll();
        modelStep(rst, fl, iv, val, ordy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        logic [7:0] expVals [4];

        reset = 1'b1; flush = 1'b0; inValid = 1'b0; inValue = 8'h00; outReady = 1'b0;
        mDrop1 = 1'b0; mDropCount1 = 0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset held two cycles with a write pending.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hEF, 1'b0);
        checkOutput("t1 valid",  32'(outValid0), 32'd0);
        checkOutput("t1 ready",  32'(inReady0),  32'd1);
        checkOutput("t1 level",  32'(level0),    32'd0);
        checkOutput("t1 aempty", 32'(aempty0),   32'd1);

        // Fill then drain.
        expVals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, expVals[i], 1'b0);
            checkOutput("t2 level", 32'(level0), 32'(i + 1));
            checkOutput("t2 afull", 32'(afull0), 32'(i >= 2));
        end
        checkOutput("t2 ready at full", 32'(inReady0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2 drain", 32'(outValue0), 32'(expVals[i]));
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkOutput("t2 empty", 32'(outValid0), 32'd0);

        // Concurrent push/pop across the pointer wrap.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h50, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h51, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("t3 seq",   32'(outValue0), 32'(8'h50 + i));
            checkOutput("t3 level", 32'(level0),    32'd2);
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h52 + i), 1'b1);
        end

        // Full with a concurrent pop: push refused, slot frees next cycle.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h60, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h61, 1'b0);
        checkOutput("t4 full level", 32'(level0), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h62, 1'b1);
        checkOutput("t4 level", 32'(level0),   32'd3);
        checkOutput("t4 ready", 32'(inReady0), 32'd1);

        // Flush with a concurrent write.
        checkOutput("t5 pre level", 32'(level0), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h70, 1'b0);
        checkOutput("t5 level", 32'(level0),    32'd0);
        checkOutput("t5 valid", 32'(outValid0), 32'd0);

        // Drop mode: six writes into a depth-4 FIFO from reset.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'hA1 + i), 1'b0);
            if (drop1) pulses++;
        end
        checkOutput("t6 pulses",  pulses,            32'd2);
        checkOutput("t6 dropcnt", 32'(dropCount1),   32'd2);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t6 drain", 32'(outValue1), 32'(8'hA1 + i));
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkOutput("t6 empty", 32'(outValid1), 32'd0);

        // Randomized traffic against the models.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 1),
                          ($urandom_range(0, 99) < 3),
                          ($urandom_range(0, 99) < 65),
                          8'($urandom),
                          ($urandom_range(0, 99) < 50));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
